mreq_arbiter: RTL and testbench
===============================

MREQ_ARBITER -- requirements
Module: mreq_arbiter

Interface
REQ-001 Parameter MREQ_NBIT, default 44, width of one packed MREQ word (wr, aincr, wsize, wcount, addr).
REQ-002 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-003 clk  input  1  system clock, posedge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 s_mreq_valid  input  2  per-requester MREQ valid, bit i = requester i.
REQ-006 s_mreq_ready  output  2  per-requester MREQ completion pulse.
REQ-007 s_mreq  input  2*MREQ_NBIT  packed MREQs, requester i at [i*MREQ_NBIT +: MREQ_NBIT].
REQ-008 s_rx_valid  input  2  per-requester write-data byte valid.
REQ-009 s_rx_data  input  16  per-requester write-data bytes, requester i at [i*8 +: 8].
REQ-010 s_rx_ready  output  2  per-requester write-data ready.
REQ-011 s_tx_valid  output  2  per-requester read-data byte valid.
REQ-012 s_tx_data  output  8  read-data byte, shared by both requesters.
REQ-013 s_tx_ready  input  2  per-requester read-data ready.
REQ-014 m_mreq_valid, m_mreq_ready, m_mreq  output/input/output  1/1/MREQ_NBIT  MREQ port to the Wishbone command engine.
REQ-015 m_rx_valid, m_rx_data, m_rx_ready  output/output/input  1/8/1  write-data stream to the engine.
REQ-016 m_tx_valid, m_tx_data, m_tx_ready  input/input/output  1/8/1  read-data stream from the engine.
REQ-017 grant  output  2  one-hot current owner, 2'b00 when idle.

Function
REQ-018 The FSM SHALL have exactly two states: IDLE and BUSY, plus a 1-bit grant index g and a 1-bit last-served pointer lp.
REQ-019 In IDLE, when any s_mreq_valid bit is set, the FSM SHALL register g and enter BUSY on the next clock; no request is forwarded in the IDLE cycle.
REQ-020 Round-robin: a single requester SHALL always win; on simultaneous requests the winner SHALL be the requester other than lp; lp SHALL be loaded with g at grant time.
REQ-021 In BUSY: m_mreq = s_mreq slice g and m_mreq_valid = s_mreq_valid[g]; in IDLE, m_mreq_valid = 0 and m_mreq = 0.
REQ-022 s_mreq_ready[g] SHALL equal m_mreq_ready in BUSY; all other s_mreq_ready bits SHALL be 0.
REQ-023 The grant SHALL be held from entry to BUSY until the cycle in which m_mreq_valid && m_mreq_ready; the FSM SHALL then return to IDLE (one dead cycle minimum between transactions).
REQ-024 Requester deassertion of valid mid-transaction SHALL NOT release the grant; only m_mreq_ready releases it.
REQ-025 Rx path in BUSY: m_rx_valid = s_rx_valid[g], m_rx_data = s_rx_data slice g, s_rx_ready[g] = m_rx_ready; all others 0; in IDLE m_rx_valid = 0.
REQ-026 Tx path in BUSY: s_tx_valid[g] = m_tx_valid, m_tx_ready = s_tx_ready[g], s_tx_data = m_tx_data; non-granted bits 0; in IDLE m_tx_ready = 0.
REQ-027 Stream and MREQ muxing SHALL be combinational from registered g and state; zero added latency in BUSY.
REQ-028 grant SHALL be one-hot of g in BUSY, 2'b00 in IDLE.

Reset
REQ-029 On rst: state = IDLE, g = 0, lp = 1 (requester 0 wins first contention), hence all outputs 0.
REQ-030 rst mid-transaction SHALL drop the grant at the next edge; the engine is reset by the same rst.

Configuration
REQ-031 Macro MREQ_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win contention and lp is unused; when undefined, round-robin per REQ-020.

Verification
REQ-032 Single req: s_mreq_valid=01, wr=0, wcount=0, wsize=4B -> grant=01 one cycle later, 4 tx bytes reach s_tx_valid[0] only, s_mreq_ready[0] pulses once, then grant=00.
REQ-033 Contention RR: both valid from reset -> order 0,1,0,1 over four transactions; each completion followed by one IDLE cycle.
REQ-034 Fixed prio (MREQ_ARB_FIXED_PRIO_EN): both valid continuously -> requester 0 served every time, s_mreq_ready[1] never pulses.
REQ-035 Write isolation: requester 1 granted, wr=1, wcount=1, 2-byte words, s_rx_valid=11 -> only s_rx_data[15:8] forwarded, s_rx_ready[0]=0 throughout.
REQ-036 Valid drop: requester 0 deasserts valid in BUSY -> grant stays 01 until m_mreq_ready; rst asserted mid-BUSY -> grant=00, all outputs 0 next cycle.

Source files
------------

// File: rtl/mreq_arbiter.sv
// Two-requester MREQ arbiter in front of a single Wishbone command engine.
// Round-robin by default; define MREQ_ARB_FIXED_PRIO_EN to make requester 0 always win.
module mreq_arbiter #(
  parameter int unsigned MREQ_NBIT = 44
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic [1:0]             s_mreq_valid,
  output logic [1:0]             s_mreq_ready,
  input  logic [2*MREQ_NBIT-1:0] s_mreq,

  input  logic [1:0]             s_rx_valid,
  input  logic [15:0]            s_rx_data,
  output logic [1:0]             s_rx_ready,

  output logic [1:0]             s_tx_valid,
  output logic [7:0]             s_tx_data,
  input  logic [1:0]             s_tx_ready,

  output logic                   m_mreq_valid,
  input  logic                   m_mreq_ready,
  output logic [MREQ_NBIT-1:0]   m_mreq,

  output logic                   m_rx_valid,
  output logic [7:0]             m_rx_data,
  input  logic                   m_rx_ready,

  input  logic                   m_tx_valid,
  input  logic [7:0]             m_tx_data,
  output logic                   m_tx_ready,

  output logic [1:0]             grant
);

  localparam logic StIdle = 1'b0;
  localparam logic StBusy = 1'b1;

  logic state_q, state_d;
  logic g_q, g_d;
  logic win;

`ifdef MREQ_ARB_FIXED_PRIO_EN
  always_comb begin
    win = (s_mreq_valid == 2'b10);
  end
`else
  logic lp_q, lp_d;

  // Lone requester wins outright; on contention the one not served last wins.
  always_comb begin
    win = 1'b0;
    if (s_mreq_valid == 2'b10) begin
      win = 1'b1;
    end else if (s_mreq_valid == 2'b11) begin
      win = ~lp_q;
    end
  end

  always_comb begin
    lp_d = lp_q;
    if (state_q == StIdle && s_mreq_valid != 2'b00) begin
      lp_d = win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lp_q <= 1'b1;
    end else begin
      lp_q <= lp_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    case (state_q)
      StIdle: begin
        if (s_mreq_valid != 2'b00) begin
          state_d = StBusy;
          g_d     = win;
        end
      end
      default: begin
        // Only an accepted MREQ ends the transaction; a dropped valid does not.
        if (m_mreq_valid && m_mreq_ready) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      g_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
    end
  end

  always_comb begin
    s_mreq_ready = 2'b00;
    s_rx_ready   = 2'b00;
    s_tx_valid   = 2'b00;
    s_tx_data    = 8'h00;
    m_mreq_valid = 1'b0;
    m_mreq       = '0;
    m_rx_valid   = 1'b0;
    m_rx_data    = 8'h00;
    m_tx_ready   = 1'b0;
    grant        = 2'b00;
    if (state_q == StBusy) begin
      grant[g_q]        = 1'b1;
      m_mreq_valid      = s_mreq_valid[g_q];
      m_mreq            = g_q ? s_mreq[2*MREQ_NBIT-1:MREQ_NBIT] : s_mreq[MREQ_NBIT-1:0];
      s_mreq_ready[g_q] = m_mreq_ready;
      m_rx_valid        = s_rx_valid[g_q];
      m_rx_data         = g_q ? s_rx_data[15:8] : s_rx_data[7:0];
      s_rx_ready[g_q]   = m_rx_ready;
      s_tx_valid[g_q]   = m_tx_valid;
      s_tx_data         = m_tx_data;
      m_tx_ready        = s_tx_ready[g_q];
    end
  end

endmodule

// File: tb/tb_mreq_arbiter.sv
// Self-checking bench for mreq_arbiter: per-cycle reference model plus directed scenarios.
// Honours MREQ_ARB_FIXED_PRIO_EN the same way the design does.
module tb_mreq_arbiter;

  localparam int N = 44;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     s_mreq_valid = '0;
  logic [1:0]     s_mreq_ready;
  logic [2*N-1:0] s_mreq = '0;
  logic [1:0]     s_rx_valid = '0;
  logic [15:0]    s_rx_data = '0;
  logic [1:0]     s_rx_ready;
  logic [1:0]     s_tx_valid;
  logic [7:0]     s_tx_data;
  logic [1:0]     s_tx_ready = '0;
  logic           m_mreq_valid;
  logic           m_mreq_ready = 1'b0;
  logic [N-1:0]   m_mreq;
  logic           m_rx_valid;
  logic [7:0]     m_rx_data;
  logic           m_rx_ready = 1'b0;
  logic           m_tx_valid = 1'b0;
  logic [7:0]     m_tx_data = '0;
  logic           m_tx_ready;
  logic [1:0]     grant;

  mreq_arbiter #(.MREQ_NBIT(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_mreq_valid (s_mreq_valid),
    .s_mreq_ready (s_mreq_ready),
    .s_mreq       (s_mreq),
    .s_rx_valid   (s_rx_valid),
    .s_rx_data    (s_rx_data),
    .s_rx_ready   (s_rx_ready),
    .s_tx_valid   (s_tx_valid),
    .s_tx_data    (s_tx_data),
    .s_tx_ready   (s_tx_ready),
    .m_mreq_valid (m_mreq_valid),
    .m_mreq_ready (m_mreq_ready),
    .m_mreq       (m_mreq),
    .m_rx_valid   (m_rx_valid),
    .m_rx_data    (m_rx_data),
    .m_rx_ready   (m_rx_ready),
    .m_tx_valid   (m_tx_valid),
    .m_tx_data    (m_tx_data),
    .m_tx_ready   (m_tx_ready),
    .grant        (grant)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: owner is -1 when nobody holds the engine.
  int owner = -1;
  int last  = 1;
  bit fixed_prio;
  initial begin
`ifdef MREQ_ARB_FIXED_PRIO_EN
    fixed_prio = 1'b1;
`else
    fixed_prio = 1'b0;
`endif
  end

  always @(posedge clk) begin
    if (rst) begin
      owner = -1;
      last  = 1;
    end else if (owner < 0) begin
      if (s_mreq_valid == 2'b11) begin
        owner = fixed_prio ? 0 : 1 - last;
        last  = owner;
      end else if (s_mreq_valid != 2'b00) begin
        owner = s_mreq_valid[1] ? 1 : 0;
        last  = owner;
      end
    end else if (s_mreq_valid[owner] && m_mreq_ready) begin
      owner = -1;
    end
  end

  function automatic logic [79:0] model_out();
    logic [1:0]   smr, srr, stv, gr;
    logic [7:0]   std, mrd;
    logic         mmv, mrv, mtr;
    logic [N-1:0] mm;
    {smr, srr, stv, gr} = '0;
    {std, mrd, mmv, mrv, mtr} = '0;
    mm = '0;
    if (owner >= 0) begin
      smr[owner] = m_mreq_ready;
      srr[owner] = m_rx_ready;
      stv[owner] = m_tx_valid;
      std        = m_tx_data;
      mmv        = s_mreq_valid[owner];
      mm         = s_mreq[owner*N +: N];
      mrv        = s_rx_valid[owner];
      mrd        = s_rx_data[owner*8 +: 8];
      mtr        = s_tx_ready[owner];
      gr[owner]  = 1'b1;
    end
    return {9'd0, smr, srr, stv, std, mmv, mm, mrv, mrd, mtr, gr};
  endfunction

  logic [79:0] act_vec;
  assign act_vec = {9'd0, s_mreq_ready, s_rx_ready, s_tx_valid, s_tx_data, m_mreq_valid,
                    m_mreq, m_rx_valid, m_rx_data, m_tx_ready, grant};

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) chk("cycle_model", act_vec, model_out());
  end

  function automatic logic [N-1:0] mk(input logic wr, input logic [1:0] wsize,
                                      input logic [7:0] wcount, input logic [31:0] addr);
    return {wr, 1'b1, wsize, wcount, addr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_mreq_valid = '0; s_rx_valid = '0; s_tx_ready = '0;
    m_mreq_ready = 1'b0; m_rx_ready = 1'b0; m_tx_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output logic [1:0] g);
    int n = 0;
    @(negedge clk);
    while (grant == 2'b00 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (grant == 2'b00) begin
      total++;
      $display("FAIL wait_grant: grant stayed 00 for %0d cycles, expected a grant", n);
    end
    g = grant;
  endtask

  logic [N-1:0] w0, w1;
  logic [1:0]   g;
  logic [1:0]   exp_g;

  initial begin
    w0 = mk(1'b0, 2'd2, 8'd0, 32'h0000_0100);
    w1 = mk(1'b1, 2'd1, 8'd1, 32'h0000_2000);

    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", act_vec, 80'd0);

    // Single request from requester 0, four read bytes back.
    tick();
    s_mreq_valid = 2'b01;
    s_mreq = {w1, w0};
    s_tx_ready = 2'b11;
    @(negedge clk);
    chk("idle_cycle_grant", 80'(grant), 80'(2'b00));
    chk("idle_cycle_mreq_valid", 80'(m_mreq_valid), 80'd0);
    tick();
    @(negedge clk);
    chk("single_grant", 80'(grant), 80'(2'b01));
    chk("single_mreq", 80'(m_mreq), 80'(w0));
    for (int i = 0; i < 4; i++) begin
      tick();
      m_tx_valid = 1'b1;
      m_tx_data  = 8'hA0 + 8'(i);
      @(negedge clk);
      chk("single_tx_valid", 80'(s_tx_valid), 80'(2'b01));
      chk("single_tx_data", 80'(s_tx_data), 80'(8'hA0 + 8'(i)));
    end
    tick();
    m_tx_valid = 1'b0;
    m_mreq_ready = 1'b1;
    @(negedge clk);
    chk("single_mreq_ready", 80'(s_mreq_ready), 80'(2'b01));
    tick();
    m_mreq_ready = 1'b0;
    s_mreq_valid = 2'b00;
    @(negedge clk);
    chk("single_release", 80'(grant), 80'(2'b00));
    chk("single_ready_once", 80'(s_mreq_ready), 80'd0);

    // Contention from reset: 0,1,0,1 round-robin, or 0 every time with fixed priority.
    do_reset();
    s_mreq_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_grant(g);
      exp_g = (fixed_prio || t % 2 == 0) ? 2'b01 : 2'b10;
      chk("contention_order", 80'(g), 80'(exp_g));
      tick();
      m_mreq_ready = 1'b1;
      tick();
      m_mreq_ready = 1'b0;
      @(negedge clk);
      chk("contention_dead_cycle", 80'(grant), 80'(2'b00));
    end

    // Write isolation with requester 1 owning the engine.
    do_reset();
    s_mreq_valid = 2'b10;
    tick();
    @(negedge clk);
    chk("wr_grant", 80'(grant), 80'(2'b10));
    chk("wr_mreq", 80'(m_mreq), 80'(w1));
    tick();
    s_rx_valid = 2'b11;
    m_rx_ready = 1'b1;
    s_rx_data  = 16'h5A_C3;
    @(negedge clk);
    chk("wr_byte0", 80'({m_rx_valid, m_rx_data}), 80'({1'b1, 8'h5A}));
    chk("wr_rx_ready0", 80'(s_rx_ready), 80'(2'b10));
    tick();
    s_rx_data  = 16'h3C_99;
    @(negedge clk);
    chk("wr_byte1", 80'({m_rx_valid, m_rx_data}), 80'({1'b1, 8'h3C}));
    chk("wr_rx_ready1", 80'(s_rx_ready), 80'(2'b10));
    tick();
    s_rx_valid = 2'b00;
    m_rx_ready = 1'b0;
    m_mreq_ready = 1'b1;
    tick();
    m_mreq_ready = 1'b0;
    s_mreq_valid = 2'b00;
    @(negedge clk);
    chk("wr_release", 80'(grant), 80'(2'b00));

    // Valid dropped mid-transaction must not release the grant.
    s_mreq_valid = 2'b01;
    tick();
    s_mreq_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_hold_grant", 80'(grant), 80'(2'b01));
      chk("drop_mreq_valid", 80'(m_mreq_valid), 80'd0);
      tick();
    end
    s_mreq_valid = 2'b01;
    m_mreq_ready = 1'b1;
    tick();
    m_mreq_ready = 1'b0;
    s_mreq_valid = 2'b00;
    @(negedge clk);
    chk("drop_release", 80'(grant), 80'(2'b00));

    // Reset while busy drops everything at the next edge.
    s_mreq_valid = 2'b10;
    tick();
    m_tx_valid = 1'b1;
    m_tx_data  = 8'h77;
    s_tx_ready = 2'b11;
    s_rx_valid = 2'b11;
    m_rx_ready = 1'b1;
    @(negedge clk);
    chk("rst_pre_grant", 80'(grant), 80'(2'b10));
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_mid_busy", act_vec, 80'd0);
    rst = 1'b0;
    s_mreq_valid = 2'b00;
    m_tx_valid = 1'b0;
    s_rx_valid = 2'b00;
    m_rx_ready = 1'b0;
    tick();
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
